// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Bundles the scancode input strobe and the decoded synth control outputs.
//   master : byte source / control consumer (PS/2 receiver side, IO controller side)
//   slave  : the decoder itself
//   Signals:
//     ps2_byte[7:0]       scancode byte, valid when ps2_byte_en is high
//     ps2_byte_en         one-cycle strobe
//     note_in             a note key is held
//     note[3:0]           sounding note 0..11
//     octave_plus_plus    one-cycle octave up step
//     octave_minus_minus  one-cycle octave down step
//     ADSR_selector[2:0]  selected ADSR parameter 0..4
//     ADSR_plus_plus      one-cycle ADSR up step
//     ADSR_minus_minus    one-cycle ADSR down step
interface ps2_key_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic       note_in;
  logic [3:0] note;
  logic       octave_plus_plus;
  logic       octave_minus_minus;
  logic [2:0] ADSR_selector;
  logic       ADSR_plus_plus;
  logic       ADSR_minus_minus;

  modport master (
    output ps2_byte, ps2_byte_en,
    input  note_in, note, octave_plus_plus, octave_minus_minus,
           ADSR_selector, ADSR_plus_plus, ADSR_minus_minus
  );

  modport slave (
    input  ps2_byte, ps2_byte_en,
    output note_in, note, octave_plus_plus, octave_minus_minus,
           ADSR_selector, ADSR_plus_plus, ADSR_minus_minus
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the PS/2 scancode byte stream into synth controls: held-note gate and
//   note number (last-pressed priority), octave/ADSR step pulses and the ADSR
//   parameter selector. Handles F0 break and E0 extended prefixes, suppresses
//   typematic repeats and aborts a stalled prefix after PREFIX_TIMEOUT cycles.
//   Ports:
//     clk    system clock
//     reset  asynchronous active-low reset
//     bus    ps2_key_decoder_if.slave (byte strobe in, controls out)
//   All outputs are registered: a byte strobed in cycle t shows at t+1.
module ps2_key_decoder #(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter bit NOTE_FALLBACK  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  ps2_key_decoder_if.slave    bus
);

  localparam int              CNT_W    = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  // Step mask / pulse bit positions.
  localparam int STEP_OCT_DN  = 0;
  localparam int STEP_OCT_UP  = 1;
  localparam int STEP_ADSR_DN = 2;
  localparam int STEP_ADSR_UP = 3;

  // {hit, index}
  function automatic logic [4:0] note_lookup(input logic [7:0] code);
    case (code)
      8'h1C:   return {1'b1, 4'd0};
      8'h1D:   return {1'b1, 4'd1};
      8'h1B:   return {1'b1, 4'd2};
      8'h24:   return {1'b1, 4'd3};
      8'h23:   return {1'b1, 4'd4};
      8'h2B:   return {1'b1, 4'd5};
      8'h2C:   return {1'b1, 4'd6};
      8'h34:   return {1'b1, 4'd7};
      8'h35:   return {1'b1, 4'd8};
      8'h33:   return {1'b1, 4'd9};
      8'h3C:   return {1'b1, 4'd10};
      8'h3B:   return {1'b1, 4'd11};
      default: return 5'd0;
    endcase
  endfunction

  // {hit, step bit}
  function automatic logic [2:0] step_lookup(input logic [7:0] code);
    case (code)
      8'h1A:   return {1'b1, 2'(STEP_OCT_DN)};
      8'h22:   return {1'b1, 2'(STEP_OCT_UP)};
      8'h4E:   return {1'b1, 2'(STEP_ADSR_DN)};
      8'h55:   return {1'b1, 2'(STEP_ADSR_UP)};
      default: return 3'd0;
    endcase
  endfunction

  // {hit, selector value}
  function automatic logic [3:0] sel_lookup(input logic [7:0] code);
    case (code)
      8'h16:   return {1'b1, 3'd0};
      8'h1E:   return {1'b1, 3'd1};
      8'h26:   return {1'b1, 3'd2};
      8'h25:   return {1'b1, 3'd3};
      8'h2E:   return {1'b1, 3'd4};
      default: return 4'd0;
    endcase
  endfunction

  // Keyboard self-test / ack / resend / error codes: never part of a key sequence.
  function automatic logic is_noise(input logic [7:0] code);
    return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
           (code == 8'h00) || (code == 8'hFF);
  endfunction

  function automatic logic [3:0] lowest_index(input logic [11:0] mask);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      note_mask_q, note_mask_d;
  logic [3:0]       step_mask_q, step_mask_d;
  logic [3:0]       note_q, note_d;
  logic             note_in_q, note_in_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       pulse_q, pulse_d;

  logic             do_make, do_break;
  logic [4:0]       nk;
  logic [2:0]       sk;
  logic [3:0]       vk;
  logic [11:0]      remaining;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    note_mask_d = note_mask_q;
    step_mask_d = step_mask_q;
    note_d      = note_q;
    note_in_d   = note_in_q;
    sel_d       = sel_q;
    pulse_d     = 4'd0;
    do_make     = 1'b0;
    do_break    = 1'b0;
    remaining   = 12'd0;
    nk          = note_lookup(bus.ps2_byte);
    sk          = step_lookup(bus.ps2_byte);
    vk          = sel_lookup(bus.ps2_byte);

    // A strobe always takes priority over prefix timeout expiry.
    if (bus.ps2_byte_en) begin
      cnt_d = '0;
      if (is_noise(bus.ps2_byte)) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.ps2_byte == 8'hF0)      state_d = BRK;
            else if (bus.ps2_byte == 8'hE0) state_d = EXT;
            else                            do_make = 1'b1;
          end
          BRK: begin
            do_break = 1'b1;
            state_d  = IDLE;
          end
          EXT:     state_d = (bus.ps2_byte == 8'hF0) ? EXT_BRK : IDLE;
          EXT_BRK: state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (do_make) begin
      if (nk[4] && !note_mask_q[nk[3:0]]) begin
        note_mask_d[nk[3:0]] = 1'b1;
        note_d               = nk[3:0];
        note_in_d            = 1'b1;
      end
      if (sk[2] && !step_mask_q[sk[1:0]]) begin
        step_mask_d[sk[1:0]] = 1'b1;
        pulse_d[sk[1:0]]     = 1'b1;
      end
      if (vk[3]) sel_d = vk[2:0];
    end

    if (do_break) begin
      if (nk[4]) begin
        remaining           = note_mask_q;
        remaining[nk[3:0]]  = 1'b0;
        note_mask_d         = remaining;
        // Only releasing the sounding key changes the gate or note.
        if (note_in_q && (note_q == nk[3:0])) begin
          if (remaining == 12'd0)  note_in_d = 1'b0;
          else if (NOTE_FALLBACK)  note_d    = lowest_index(remaining);
          else                     note_in_d = 1'b0;
        end
      end
      if (sk[2]) step_mask_d[sk[1:0]] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      note_mask_q <= '0;
      step_mask_q <= '0;
      note_q      <= '0;
      note_in_q   <= 1'b0;
      sel_q       <= '0;
      pulse_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples this cycle's values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      note_mask_q <= note_mask_d;
      step_mask_q <= step_mask_d;
      note_q      <= note_d;
      note_in_q   <= note_in_d;
      sel_q       <= sel_d;
      pulse_q     <= pulse_d;
    end
  end

  assign bus.note_in            = note_in_q;
  assign bus.note               = note_q;
  assign bus.ADSR_selector      = sel_q;
  assign bus.octave_minus_minus = pulse_q[STEP_OCT_DN];
  assign bus.octave_plus_plus   = pulse_q[STEP_OCT_UP];
  assign bus.ADSR_minus_minus   = pulse_q[STEP_ADSR_DN];
  assign bus.ADSR_plus_plus     = pulse_q[STEP_ADSR_UP];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder. Two instances share the stimulus:
//   dut_a with NOTE_FALLBACK=1, dut_b with NOTE_FALLBACK=0. A short prefix
//   timeout keeps the timeout scenario brief.
module tb_ps2_key_decoder;

  localparam int TO = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ps2_key_decoder_if if_a ();
  ps2_key_decoder_if if_b ();

  ps2_key_decoder #(.PREFIX_TIMEOUT(TO), .NOTE_FALLBACK(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  ps2_key_decoder #(.PREFIX_TIMEOUT(TO), .NOTE_FALLBACK(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte into both instances; returns on the negedge after the
  // strobe edge, where the registered outputs for that byte are visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    if_a.ps2_byte = b; if_a.ps2_byte_en = 1'b1;
    if_b.ps2_byte = b; if_b.ps2_byte_en = 1'b1;
    @(negedge clk);
    if_a.ps2_byte_en = 1'b0;
    if_b.ps2_byte_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    if_a.ps2_byte = 8'h00; if_a.ps2_byte_en = 1'b0;
    if_b.ps2_byte = 8'h00; if_b.ps2_byte_en = 1'b0;
    idle(3);

    // Reset state
    check("rst_note_in", 8'(if_a.note_in), 8'd0);
    check("rst_note",    8'(if_a.note), 8'd0);
    check("rst_sel",     8'(if_a.ADSR_selector), 8'd0);
    check("rst_pulses",  8'({if_a.octave_plus_plus, if_a.octave_minus_minus,
                             if_a.ADSR_plus_plus, if_a.ADSR_minus_minus}), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Single note make / break
    send(8'h1C);
    check("make_A_note_in", 8'(if_a.note_in), 8'd1);
    check("make_A_note",    8'(if_a.note), 8'd0);
    send(8'hF0);
    check("f0_no_change",   8'(if_a.note_in), 8'd1);
    send(8'h1C);
    check("brk_A_note_in",  8'(if_a.note_in), 8'd0);
    check("brk_A_note",     8'(if_a.note), 8'd0);

    // Last-pressed priority and fallback (E=24 is index 3)
    send(8'h1C);
    check("A_note", 8'(if_a.note), 8'd0);
    send(8'h24);
    check("E_note",    8'(if_a.note), 8'd3);
    check("E_note_in", 8'(if_a.note_in), 8'd1);
    send(8'h1C);
    check("A_repeat_ignored", 8'(if_a.note), 8'd3);
    send(8'hF0);
    send(8'h24);
    check("fb1_note",      8'(if_a.note), 8'd0);
    check("fb1_note_in",   8'(if_a.note_in), 8'd1);
    check("fb0_note_in",   8'(if_b.note_in), 8'd0);
    send(8'hF0);
    send(8'h1C);
    check("all_released",  8'(if_a.note_in), 8'd0);

    // Back-to-back strobes: W=1D (1) then D=23 (4) on consecutive cycles
    @(negedge clk);
    if_a.ps2_byte = 8'h1D; if_a.ps2_byte_en = 1'b1;
    if_b.ps2_byte = 8'h1D; if_b.ps2_byte_en = 1'b1;
    @(negedge clk);
    check("b2b_first", 8'(if_a.note), 8'd1);
    if_a.ps2_byte = 8'h23;
    if_b.ps2_byte = 8'h23;
    @(negedge clk);
    if_a.ps2_byte_en = 1'b0;
    if_b.ps2_byte_en = 1'b0;
    check("b2b_second", 8'(if_a.note), 8'd4);
    send(8'hF0);
    send(8'h23);
    check("b2b_fallback", 8'(if_a.note), 8'd1);
    send(8'hF0);
    send(8'h1D);
    check("b2b_released", 8'(if_a.note_in), 8'd0);

    // Octave+ typematic suppression
    send(8'h22);
    check("oct_up_1st", 8'(if_a.octave_plus_plus), 8'd1);
    check("oct_dn_quiet", 8'(if_a.octave_minus_minus), 8'd0);
    idle(1);
    check("oct_up_one_cycle", 8'(if_a.octave_plus_plus), 8'd0);
    for (int i = 0; i < 4; i++) begin
      send(8'h22);
      check("oct_up_repeat", 8'(if_a.octave_plus_plus), 8'd0);
    end
    send(8'hF0);
    send(8'h22);
    check("oct_up_break", 8'(if_a.octave_plus_plus), 8'd0);
    send(8'h22);
    check("oct_up_2nd", 8'(if_a.octave_plus_plus), 8'd1);
    idle(1);
    check("oct_up_2nd_end", 8'(if_a.octave_plus_plus), 8'd0);
    send(8'hF0);
    send(8'h22);
    send(8'h1A);
    check("oct_dn", 8'(if_a.octave_minus_minus), 8'd1);
    send(8'hF0);
    send(8'h1A);

    // Selector and ADSR steps, extended codes discarded
    send(8'h26);
    check("sel_2", 8'(if_a.ADSR_selector), 8'd2);
    send(8'h55);
    check("adsr_up", 8'(if_a.ADSR_plus_plus), 8'd1);
    send(8'hF0);
    send(8'h55);
    check("adsr_up_brk", 8'(if_a.ADSR_plus_plus), 8'd0);
    send(8'hE0);
    send(8'h55);
    check("ext_make_no_pulse", 8'(if_a.ADSR_plus_plus), 8'd0);
    send(8'hE0);
    send(8'hF0);
    send(8'h55);
    check("ext_brk_no_pulse", 8'(if_a.ADSR_plus_plus), 8'd0);
    check("ext_sel_kept", 8'(if_a.ADSR_selector), 8'd2);
    send(8'h55);
    check("adsr_up_again", 8'(if_a.ADSR_plus_plus), 8'd1);
    send(8'h4E);
    check("adsr_dn", 8'(if_a.ADSR_minus_minus), 8'd1);
    send(8'h2E);
    check("sel_4", 8'(if_a.ADSR_selector), 8'd4);
    send(8'hF0);
    send(8'h2E);
    check("sel_brk_ignored", 8'(if_a.ADSR_selector), 8'd4);

    // Noise byte aborts a break prefix
    send(8'hF0);
    send(8'hAA);
    send(8'h1C);
    check("noise_abort_make", 8'(if_a.note_in), 8'd1);
    send(8'hF0);
    send(8'h1C);
    check("noise_release", 8'(if_a.note_in), 8'd0);

    // Prefix still live just before timeout: byte is a break
    send(8'h1C);
    send(8'hF0);
    idle(TO - 4);
    send(8'h1C);
    check("pre_timeout_break", 8'(if_a.note_in), 8'd0);

    // Prefix timed out: byte is a make
    send(8'hF0);
    idle(TO + 3);
    send(8'h1C);
    check("timeout_make", 8'(if_a.note_in), 8'd1);
    check("timeout_note", 8'(if_a.note), 8'd0);

    // Reset mid-sequence (A held, F0 pending)
    send(8'h24);
    send(8'hF0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mid_rst_note_in", 8'(if_a.note_in), 8'd0);
      check("mid_rst_note",    8'(if_a.note), 8'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    send(8'h1C);
    check("post_rst_note_in", 8'(if_a.note_in), 8'd1);
    check("post_rst_note",    8'(if_a.note), 8'd0);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the run in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
